// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state encoding, widths and strobe decode for the multiplier controller
package mul_pkg;

  localparam int STATE_W = 3;
  localparam int DATA_W  = 16;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_CHECK  = 3'd3,
    S_ADD    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  typedef struct packed {
    logic ld_a;
    logic ld_b;
    logic clr_p;
    logic ld_p;
    logic dec_b;
    logic busy;
    logic done;
  } strobes_t;

  // Moore decode: the strobe set belonging to a state
  function automatic strobes_t decode(input state_t s);
    strobes_t o;
    o = '0;
    o.busy = (s != S_IDLE);
    case (s)
      S_LOAD_A: o.ld_a = 1'b1;
      S_LOAD_B: begin
        o.ld_b  = 1'b1;
        o.clr_p = 1'b1;
      end
      S_ADD: begin
        o.ld_p  = 1'b1;
        o.dec_b = 1'b1;
      end
      S_DONE:  o.done = 1'b1;
      default: o.busy = (s != S_IDLE);
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mul_ctrl.sv
// rtl/mul_ctrl.sv - control FSM for the repeated-addition multiplier with watchdog and abort
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int                ITER_W   = 16,
  parameter logic [ITER_W-1:0] MAX_ITER = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              eqz,
  output logic              ldA,
  output logic              ldB,
  output logic              clrP,
  output logic              ldP,
  output logic              decB,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter
);

  state_t   state;
  state_t   state_nxt;
  strobes_t strb;
  logic     limit_hit;

  assign limit_hit = (iter == MAX_ITER);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = start ? S_LOAD_A : S_IDLE;
      S_LOAD_A: state_nxt = abort ? S_IDLE : S_LOAD_B;
      S_LOAD_B: state_nxt = abort ? S_IDLE : S_CHECK;
      S_CHECK: begin
        if (abort)                  state_nxt = S_IDLE;
        else if (eqz || limit_hit)  state_nxt = S_DONE;
        else                        state_nxt = S_ADD;
      end
      S_ADD:    state_nxt = abort ? S_IDLE : S_CHECK;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state, so they always match the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      strb  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      strb  <= decode(state_nxt);
      if (state == S_IDLE && start)
        err <= 1'b0;
      else if (state == S_CHECK && !abort && !eqz && limit_hit)
        err <= 1'b1;
    end
  end

  // An aborted ADD does not count as an executed iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      iter <= '0;
    else if (state == S_IDLE && start)
      iter <= '0;
    else if (state == S_ADD && !abort)
      iter <= iter + 1'b1;
  end

  assign ldA  = strb.ld_a;
  assign ldB  = strb.ld_b;
  assign clrP = strb.clr_p;
  assign ldP  = strb.ld_p;
  assign decB = strb.dec_b;
  assign busy = strb.busy;
  assign done = strb.done;

endmodule

// File: tb/tb_mul_ctrl.sv
// tb/tb_mul_ctrl.sv - self-checking bench for mul_ctrl with a datapath model and arithmetic reference
module tb_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] din = '0;
  logic        eqz;
  logic        ldA, ldB, clrP, ldP, decB, busy, done, err;
  logic [15:0] iter;

  logic        start_w = 1'b0;
  logic        abort_w = 1'b0;
  logic        eqz_w = 1'b0;
  logic        w_ldA, w_ldB, w_clrP, w_ldP, w_decB, w_busy, w_done, w_err;
  logic [15:0] w_iter;

  logic [15:0] a_reg, b_reg, p_reg;

  int vectors = 0;
  int miscompares = 0;

  mul_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .eqz(eqz),
    .ldA(ldA), .ldB(ldB), .clrP(clrP), .ldP(ldP), .decB(decB),
    .busy(busy), .done(done), .err(err), .iter(iter)
  );

  mul_ctrl #(.ITER_W(16), .MAX_ITER(16'd4)) u_wd (
    .clk(clk), .rst_n(rst_n), .start(start_w), .abort(abort_w), .eqz(eqz_w),
    .ldA(w_ldA), .ldB(w_ldB), .clrP(w_clrP), .ldP(w_ldP), .decB(w_decB),
    .busy(w_busy), .done(w_done), .err(w_err), .iter(w_iter)
  );

  always #5 clk = ~clk;

  // A/B/P datapath the controller drives
  always @(posedge clk) begin
    if (ldA)  a_reg <= din;
    if (ldB)  b_reg <= din;
    if (decB) b_reg <= b_reg - 16'd1;
    if (clrP) p_reg <= '0;
    if (ldP)  p_reg <= p_reg + a_reg;
  end
  assign eqz = (b_reg == 16'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full multiply; reference: done in cycle 2N+4, N adds, P = A*N
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit noise);
    int          c;
    int          adds;
    bit          seen;
    int          exp_done;
    logic [15:0] exp_p;
    exp_done = 2 * int'(b) + 4;
    exp_p    = a * b;
    c = 0; adds = 0; seen = 0;
    start = 1'b1;
    step(); c = 1;
    start = 1'b0;
    din = a;
    chk("ldA_c1", 32'(ldA), 32'd1);
    chk("busy_c1", 32'(busy), 32'd1);
    step(); c = 2;
    din = b;
    chk("ldB_clrP_c2", 32'({ldB, clrP}), 32'd3);
    while (!seen && c < exp_done + 8) begin
      step(); c++;
      if (noise) start = 1'($urandom_range(0, 1));
      if (ldP) adds++;
      if (done) seen = 1;
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_cycle", 32'(c), 32'(exp_done));
    chk("add_count", 32'(adds), 32'(b));
    chk("iter", 32'(iter), 32'(b));
    chk("err_ok", 32'(err), 32'd0);
    chk("product", 32'(p_reg), 32'(exp_p));
    step();
    chk("post_done_idle", 32'({busy, done}), 32'd0);
  endtask

  initial begin
    int c;
    int dones;
    int adds;
    bit seen;

    #2;
    chk("reset_outs", 32'({ldA, ldB, clrP, ldP, decB, busy, done, err}), 32'd0);
    chk("reset_iter", 32'(iter), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // reset asserted in the middle of an ADD cycle
    start = 1'b1;
    step(); start = 1'b0; din = 16'd5;
    step(); din = 16'd3;
    step();
    step();
    chk("mid_add_ldP", 32'(ldP), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outs", 32'({ldA, ldB, clrP, ldP, decB, busy, done, err}), 32'd0);
    chk("async_reset_iter", 32'(iter), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_op(16'd5, 16'd3, 1'b0);
    run_op(16'd7, 16'd0, 1'b0);
    for (int i = 0; i < 8; i++)
      run_op(16'($urandom), 16'($urandom_range(0, 12)), 1'b1);

    // abort in the second ADD cycle, with start raised alongside it
    start = 1'b1;
    step(); start = 1'b0; din = 16'd5;
    step(); din = 16'd3;
    step();
    step();
    step();
    step();
    chk("abort_in_add", 32'(ldP), 32'd1);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_idle", 32'({busy, done, ldA, ldP}), 32'd0);
    chk("abort_iter_kept", 32'(iter), 32'd1);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done || busy) dones++;
    end
    chk("abort_no_activity", 32'(dones), 32'd0);

    // start held high: B=0 operations repeat every 5 cycles
    din = 16'd0;
    start = 1'b1;
    dones = 0;
    c = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done) begin
        dones++;
        if (c == 0) c = i;
      end
    end
    start = 1'b0;
    chk("b2b_first_done", 32'(c), 32'd4);
    chk("b2b_done_count", 32'(dones), 32'd4);
    step();
    chk("b2b_idle", 32'(busy), 32'd0);

    // watchdog instance, eqz stuck at 0
    start_w = 1'b1;
    step(); start_w = 1'b0;
    c = 1; adds = 0; seen = 0;
    while (!seen && c < 40) begin
      step(); c++;
      if (w_ldP) adds++;
      if (w_done) seen = 1;
    end
    chk("wd_done_seen", 32'(seen), 32'd1);
    chk("wd_done_cycle", 32'(c), 32'd12);
    chk("wd_err", 32'(w_err), 32'd1);
    chk("wd_iter", 32'(w_iter), 32'd4);
    chk("wd_adds", 32'(adds), 32'd4);
    step();
    chk("wd_err_held", 32'({w_err, w_busy}), 32'd2);
    start_w = 1'b1;
    step(); start_w = 1'b0;
    chk("wd_err_cleared", 32'(w_err), 32'd0);
    chk("wd_iter_cleared", 32'(w_iter), 32'd0);
    abort_w = 1'b1;
    step(); abort_w = 1'b0;
    chk("wd_abort_idle", 32'(w_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
- Control FSM for the repeated-addition multiplier datapath: A register, B register (down-counting), P accumulator, and the B==0 comparator.
- Accepts a start request and sequences the load strobes. A and B are taken from the shared 16-bit din bus on consecutive cycles.
- Iterates P <= P + A while decrementing B until B reaches zero, then pulses done.
- Adds an iteration watchdog, an abort path and a busy indication for the upstream requester.

Parameters:
- ITER_W, 16, width of the internal iteration counter and of the iter output.
- MAX_ITER, 16'hFFFF, watchdog limit. Reaching it without eqz ends the operation with err=1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- abort  input  1  synchronous abort, effective in any non-IDLE state.
- eqz  input  1  comparator output, B register == 0.
- ldA  output  1  load A register from din.
- ldB  output  1  load B register from din.
- clrP  output  1  clear P accumulator.
- ldP  output  1  load P with adder output (P+A).
- decB  output  1  decrement B register.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  watchdog flag; valid in the done cycle and held until the next start.
- iter  output  ITER_W  number of ADD cycles executed in the current or last operation.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - iter=0 and err=0.
  - All strobes, busy and done are 0.
- Outputs:
  - All strobes are Moore outputs decoded from the state register.
  - No combinational path from inputs to outputs.
- States and transitions:
  - IDLE: strobes 0. start=1 -> LOAD_A, clears iter and err at that edge.
  - LOAD_A: ldA=1. Upstream drives din=A during this cycle. Next state is LOAD_B.
  - LOAD_B: ldB=1, clrP=1. Upstream drives din=B. Next state is CHECK.
  - CHECK: no strobes.
    - eqz=1 -> DONE, err=0.
    - eqz=0 and iter==MAX_ITER -> DONE, err=1.
    - Otherwise -> ADD.
  - ADD: ldP=1, decB=1. iter increments by 1 at the exit edge. Next state is CHECK.
  - DONE: done=1 for exactly one cycle. Next state is IDLE.
- Latency: with start sampled at edge 0 and B=N, the DONE cycle is cycle 2N+4.
  - N=0 gives done in cycle 4.
  - N=3 gives done in cycle 10.
- Abort:
  - abort=1 in any state other than IDLE or DONE -> IDLE at the next edge.
  - No done pulse is produced. err and iter are left as they were.
  - abort in the DONE cycle is ignored; done still completes.
  - abort and start together in IDLE: start wins and abort is ignored.
- start while busy is ignored; there is no queueing.
- eqz is sampled only in CHECK. Its value in other states is don't-care.
- iter never wraps, because the watchdog stops the operation at MAX_ITER.
- Asynchronous reset mid-operation forces IDLE immediately. Strobes deassert asynchronously.

Decomposition:
- Package mul_pkg holds:
  - State encoding localparams (S_IDLE=0, S_LOAD_A=1, S_LOAD_B=2, S_CHECK=3, S_ADD=4, S_DONE=5) and the 3-bit state width.
  - The 16-bit datapath width constant shared with the A, B and P registers.
- No sub-module. The FSM and the iteration counter sit in one module; the counter is a single always block.

Test Plan:
- Reset asserted mid-ADD -> all outputs 0 immediately, state IDLE. After release, start works normally.
- start, A=5, B=3 -> ldA in cycle 1, ldB/clrP in cycle 2, three ldP/decB pulses, done in cycle 10, iter=3, err=0, datapath P=15.
- start, A=7, B=0 -> no ldP pulses, done in cycle 4, iter=0, P=0.
- MAX_ITER=4 with eqz held 0 -> 4 ADD cycles, then done with err=1 and iter=4; err clears on the next start.
- abort asserted in the second ADD cycle -> IDLE next edge, no done, busy drops. start in the same cycle as that abort is ignored.
- Back-to-back start held high continuously -> a new operation begins in the cycle after DONE. start pulses during busy produce no extra operations.
